// File: rtl/harq_combine_scheduler.sv
// HARQ combine scheduler: walks the users of a round and issues one combine request per valid user.
// Optional macro HARQ_SCHED_TIMEOUT_EN adds a per-user watchdog on the WAIT_COMP state.
module harq_combine_scheduler #(
    parameter int MAX_USERS      = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                      i_core_clk,
    input  logic                      i_rx_rst,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [3:0]                i_user_num,
    input  logic [4*MAX_USERS-1:0]    i_users_qm,
    input  logic [14*MAX_USERS-1:0]   i_user_e01_size_all,
    input  logic [16*MAX_USERS-1:0]   i_user_ncb_size_all,
    input  logic                      i_RDM_Data_Comp,
    output logic                      o_Combine_process_request,
    output logic [3:0]                o_Combine_user_index,
    output logic [13:0]               o_Current_Combine_E01_Size,
    output logic [15:0]               o_Current_Combine_Ncb_Size,
    output logic                      o_busy,
    output logic                      o_all_done,
    output logic [MAX_USERS-1:0]      o_user_done_mask,
    output logic [MAX_USERS-1:0]      o_user_skip_mask,
    output logic [MAX_USERS-1:0]      o_user_timeout_mask
);

    typedef enum logic [2:0] {
        IDLE, SCAN, REQ, WAIT_COMP, GAP, DONE, ABORT
    } state_t;

    localparam logic [3:0] IDX_MAX = 4'(MAX_USERS);
    localparam int         GAP_W   = $clog2(GAP_CYCLES + 2);

    state_t           state, next_state;
    logic [3:0]       idx, count, count_in, idx_next;
    logic [GAP_W-1:0] gap_cnt;
    logic [2:0]       sel;
    logic [3:0]       qm;
    logic [13:0]      e01;
    logic [15:0]      ncb;
    logic             user_valid, scan_end, gap_last, wd_hit;
    logic             req_d, done_d, busy_d;

    assign sel        = idx[2:0];
    assign qm         = i_users_qm[4*sel +: 4];
    assign e01        = i_user_e01_size_all[14*sel +: 14];
    assign ncb        = i_user_ncb_size_all[16*sel +: 16];
    assign user_valid = (qm != 4'd0) && (qm <= 4'd8) && (e01 != 14'd0);
    assign scan_end   = (idx >= count);
    assign gap_last   = (int'(gap_cnt) + 1 >= GAP_CYCLES);
    assign count_in   = (i_user_num > IDX_MAX) ? IDX_MAX : i_user_num;
    // The index saturates at the slot count instead of wrapping back to user 0.
    assign idx_next   = (idx >= IDX_MAX) ? IDX_MAX : idx + 4'd1;

`ifdef HARQ_SCHED_TIMEOUT_EN
    logic [16:0] wd;
    assign wd_hit = (wd == 17'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst)                wd <= '0;
        else if (state == WAIT_COMP) wd <= wd + 17'd1;
        else                         wd <= '0;
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst)
            o_user_timeout_mask <= '0;
        else if (state == IDLE && next_state == SCAN)
            o_user_timeout_mask <= '0;
        else if (state == WAIT_COMP && next_state == GAP && !i_RDM_Data_Comp)
            o_user_timeout_mask[sel] <= 1'b1;
    end
`else
    assign wd_hit              = 1'b0;
    assign o_user_timeout_mask = '0;
`endif

    // NOTE: state and every registered output use non-blocking assignments so all
    // flops update from the same pre-edge values.
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (i_start) next_state = SCAN;
            SCAN: begin
                if (scan_end)        next_state = DONE;
                else if (user_valid) next_state = REQ;
            end
            REQ:       next_state = WAIT_COMP;
            WAIT_COMP: if (i_RDM_Data_Comp || wd_hit) next_state = GAP;
            GAP:       if (gap_last) next_state = SCAN;
            DONE:      next_state = IDLE;
            ABORT:     next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (i_abort) next_state = ABORT;
    end

    // Output decode looks at next_state so the registered outputs line up with the state.
    always_comb begin
        req_d  = (next_state == REQ);
        done_d = (next_state == DONE);
        busy_d = (next_state != IDLE);
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            o_Combine_process_request  <= 1'b0;
            o_all_done                 <= 1'b0;
            o_busy                     <= 1'b0;
            o_Combine_user_index       <= '0;
            o_Current_Combine_E01_Size <= '0;
            o_Current_Combine_Ncb_Size <= '0;
            o_user_done_mask           <= '0;
            o_user_skip_mask           <= '0;
            idx                        <= '0;
            count                      <= '0;
            gap_cnt                    <= '0;
        end else begin
            o_Combine_process_request <= req_d;
            o_all_done                <= done_d;
            o_busy                    <= busy_d;
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (state == IDLE && next_state == SCAN) begin
                count            <= count_in;
                idx              <= '0;
                o_user_done_mask <= '0;
                o_user_skip_mask <= '0;
            end
            if (state == SCAN && next_state == SCAN) begin
                o_user_skip_mask[sel] <= 1'b1;
                idx                   <= idx_next;
            end
            if (state == SCAN && next_state == REQ) begin
                o_Combine_user_index       <= idx;
                o_Current_Combine_E01_Size <= e01;
                o_Current_Combine_Ncb_Size <= ncb;
            end
            if (state == WAIT_COMP && next_state == GAP && i_RDM_Data_Comp)
                o_user_done_mask[sel] <= 1'b1;
            if (state == GAP && next_state == SCAN)
                idx <= idx_next;
        end
    end

endmodule

// File: tb/tb_harq_combine_scheduler.sv
// Self-checking bench for harq_combine_scheduler: table-driven rounds plus abort, reset and zero-user sequences.
// Define HARQ_SCHED_TIMEOUT_EN to also exercise the watchdog (DUT built with TIMEOUT_CYCLES=100).
module tb_harq_combine_scheduler;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, comp = 1'b0;
    logic [3:0]   user_num = '0;
    logic [31:0]  qm_all = '0;
    logic [111:0] e01_all = '0;
    logic [127:0] ncb_all = '0;
    logic         req, busy, all_done;
    logic [3:0]   idx;
    logic [13:0]  e01;
    logic [15:0]  ncb;
    logic [7:0]   done_mask, skip_mask, timeout_mask;
    logic [60:0]  all_out;

    harq_combine_scheduler #(.MAX_USERS(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(100)) dut (
        .i_core_clk                 (clk),
        .i_rx_rst                   (rst),
        .i_start                    (start),
        .i_abort                    (abort),
        .i_user_num                 (user_num),
        .i_users_qm                 (qm_all),
        .i_user_e01_size_all        (e01_all),
        .i_user_ncb_size_all        (ncb_all),
        .i_RDM_Data_Comp            (comp),
        .o_Combine_process_request  (req),
        .o_Combine_user_index       (idx),
        .o_Current_Combine_E01_Size (e01),
        .o_Current_Combine_Ncb_Size (ncb),
        .o_busy                     (busy),
        .o_all_done                 (all_done),
        .o_user_done_mask           (done_mask),
        .o_user_skip_mask           (skip_mask),
        .o_user_timeout_mask        (timeout_mask)
    );

    assign all_out = {req, idx, e01, ncb, busy, all_done, done_mask, skip_mask, timeout_mask};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [3:0]   num;
        logic [31:0]  qm;
        logic [111:0] e01;
        logic [127:0] ncb;
        int           delay;
        logic [7:0]   exp_done;
        logic [7:0]   exp_skip;
    } vec_t;

    typedef struct {
        logic [3:0]  idx;
        logic [13:0] e01;
        logic [15:0] ncb;
    } req_t;

    vec_t vecs[6];
    req_t sb[$];
    req_t cur_exp;
    int   checks = 0, failures = 0;
    int   req_pulses = 0, done_pulses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: every request must match the oldest expected user.
    always @(negedge clk) begin
        if (all_done) done_pulses++;
        if (req) begin
            req_pulses++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req index=%0d expected=none", idx);
            end else begin
                cur_exp = sb.pop_front();
                check("req_index", 64'(idx), 64'(cur_exp.idx));
                check("req_e01",   64'(e01), 64'(cur_exp.e01));
                check("req_ncb",   64'(ncb), 64'(cur_exp.ncb));
            end
        end
    end

    // Reference model: which users get requested, and the first one's position.
    task automatic push_expected(input vec_t v, output int first);
        int n;
        logic [3:0] q;
        logic [13:0] e;
        n = (v.num > 4'd8) ? 8 : int'(v.num);
        first = -1;
        for (int u = 0; u < n; u++) begin
            q = v.qm[4*u +: 4];
            e = v.e01[14*u +: 14];
            if (q != 4'd0 && q <= 4'd8 && e != 14'd0) begin
                sb.push_back('{4'(u), e, v.ncb[16*u +: 16]});
                if (first < 0) first = u;
            end
        end
    endtask

    task automatic drive_start(input vec_t v);
        user_num = v.num;
        qm_all   = v.qm;
        e01_all  = v.e01;
        ncb_all  = v.ncb;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            if (req) ok = 1'b1;
            else tick();
        end
        check("req_within_budget", 64'(ok), 64'(1));
    endtask

    task automatic run_round(input vec_t v, input bit scramble);
        int first, start_cyc, d0, r0, k;
        bit got_done, seen_req;
        push_expected(v, first);
        d0 = done_pulses;
        r0 = req_pulses;
        start_cyc = cyc + 1;
        drive_start(v);
        got_done = 1'b0;
        seen_req = 1'b0;
        k = 0;
        while (!got_done && k < 3000) begin
            if (all_done) got_done = 1'b1;
            else begin
                if (req) begin
                    if (!seen_req) begin
                        seen_req = 1'b1;
                        check("first_req_latency", 64'(cyc + 1 - start_cyc), 64'(2 + first));
                    end
                    for (int w = 1; w <= v.delay; w++) begin
                        tick();
                        start = 1'b0;
                        if (scramble && w == 10) begin
                            qm_all  = ~v.qm;
                            e01_all = ~v.e01;
                            ncb_all = ~v.ncb;
                            start   = 1'b1;
                        end
                    end
                    if (scramble) begin
                        check("hold_index", 64'(idx), 64'(cur_exp.idx));
                        check("hold_e01",   64'(e01), 64'(cur_exp.e01));
                        check("hold_ncb",   64'(ncb), 64'(cur_exp.ncb));
                        qm_all  = v.qm;
                        e01_all = v.e01;
                        ncb_all = v.ncb;
                    end
                    comp = 1'b1;
                end
                tick();
                comp = 1'b0;
                k++;
            end
        end
        check("round_done_seen", 64'(got_done), 64'(1));
        check("busy_at_done", 64'(busy), 64'(1));
        check("done_mask", 64'(done_mask), 64'(v.exp_done));
        check("skip_mask", 64'(skip_mask), 64'(v.exp_skip));
        check("timeout_mask", 64'(timeout_mask), 64'(0));
        check("all_done_count", 64'(done_pulses - d0), 64'(1));
        check("sb_drained", 64'(sb.size()), 64'(0));
        if (first < 0) check("no_request", 64'(req_pulses - r0), 64'(0));
        tick();
        check("busy_after_done", 64'(busy), 64'(0));
        check("all_done_one_cycle", 64'(all_done), 64'(0));
        sb.delete();
    endtask

    initial begin
        int first, d0, r0;
        bit ok;
        vec_t v;

        for (int i = 0; i < 6; i++) begin
            for (int u = 0; u < 8; u++) begin
                vecs[i].qm[4*u +: 4]    = 4'(u + 1);
                vecs[i].e01[14*u +: 14] = 14'(100*i + 17*u + 1);
                vecs[i].ncb[16*u +: 16] = 16'(4000 + 300*i + 11*u);
            end
        end
        vecs[0].num = 4'd3;  vecs[0].delay = 20; vecs[0].exp_done = 8'h07; vecs[0].exp_skip = 8'h00;
        vecs[1].num = 4'd4;  vecs[1].delay = 4;  vecs[1].exp_done = 8'h09; vecs[1].exp_skip = 8'h06;
        vecs[1].qm[7:4] = 4'd0;
        vecs[1].e01[41:28] = 14'd0;
        vecs[2].num = 4'd0;  vecs[2].delay = 3;  vecs[2].exp_done = 8'h00; vecs[2].exp_skip = 8'h00;
        vecs[3].num = 4'd12; vecs[3].delay = 3;  vecs[3].exp_done = 8'hDF; vecs[3].exp_skip = 8'h20;
        vecs[3].qm[23:20] = 4'd9;
        vecs[4].num = 4'd8;  vecs[4].delay = 1;  vecs[4].exp_done = 8'hFF; vecs[4].exp_skip = 8'h00;
        vecs[4].qm = {8{4'd8}};
        vecs[5].num = 4'd2;  vecs[5].delay = 2;  vecs[5].exp_done = 8'h02; vecs[5].exp_skip = 8'h01;
        vecs[5].e01[13:0] = 14'd0;

        // Reset state.
        tick();
        tick();
        check("reset_outputs", 64'(all_out), 64'(0));
        rst = 1'b0;

        // Zero-user round: start sampled at edge 10, o_all_done sampled at edge 12.
        while (cyc < 9) tick();
        r0 = req_pulses;
        user_num = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10 && !all_done; k++) tick();
        check("zero_user_done_seen", 64'(all_done), 64'(1));
        check("zero_user_done_edge", 64'(cyc + 1), 64'(12));
        check("zero_user_no_req", 64'(req_pulses - r0), 64'(0));
        check("zero_user_masks", 64'({done_mask, skip_mask}), 64'(0));
        tick();
        comp = 1'b1;
        tick();
        comp = 1'b0;
        tick();
        check("comp_ignored_in_idle", 64'({done_mask, busy}), 64'(0));

        for (int i = 0; i < 6; i++) run_round(vecs[i], i == 0);

        // Abort in WAIT_COMP for user 1 together with the completion pulse.
        push_expected(vecs[0], first);
        void'(sb.pop_back());
        d0 = done_pulses;
        drive_start(vecs[0]);
        wait_req(50, ok);
        repeat (5) tick();
        comp = 1'b1;
        tick();
        comp = 1'b0;
        wait_req(50, ok);
        repeat (5) tick();
        comp = 1'b1;
        abort = 1'b1;
        tick();
        comp = 1'b0;
        abort = 1'b0;
        r0 = req_pulses;
        check("abort_req_low", 64'(req), 64'(0));
        check("abort_busy", 64'(busy), 64'(1));
        check("abort_done_mask", 64'(done_mask), 64'(8'h01));
        tick();
        check("abort_idle_busy", 64'(busy), 64'(0));
        repeat (30) tick();
        check("abort_no_all_done", 64'(done_pulses - d0), 64'(0));
        check("abort_no_more_req", 64'(req_pulses - r0), 64'(0));
        check("abort_masks_held", 64'(done_mask), 64'(8'h01));
        check("abort_sb_drained", 64'(sb.size()), 64'(0));
        sb.delete();

        // Reset while in GAP, then a fresh round.
        v = vecs[0];
        v.num = 4'd2;
        push_expected(v, first);
        drive_start(v);
        wait_req(50, ok);
        repeat (3) tick();
        comp = 1'b1;
        tick();
        comp = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_in_gap_outputs", 64'(all_out), 64'(0));
        sb.delete();
        repeat (5) tick();
        check("reset_no_pending_req", 64'(req), 64'(0));
        v.num = 4'd1;
        v.exp_done = 8'h01;
        v.exp_skip = 8'h00;
        run_round(v, 1'b0);

`ifdef HARQ_SCHED_TIMEOUT_EN
        begin
            int r;
            v = vecs[0];
            v.num = 4'd2;
            push_expected(v, first);
            drive_start(v);
            wait_req(50, ok);
            r = cyc;
            while (cyc < r + 100) tick();
            check("timeout_not_early", 64'(timeout_mask), 64'(0));
            tick();
            check("timeout_at_100", 64'(timeout_mask), 64'(8'h01));
            wait_req(50, ok);
            check("timeout_next_user", 64'(idx), 64'(1));
            repeat (3) tick();
            comp = 1'b1;
            tick();
            comp = 1'b0;
            for (int k = 0; k < 20 && !all_done; k++) tick();
            check("timeout_round_done", 64'(all_done), 64'(1));
            check("timeout_done_mask", 64'(done_mask), 64'(8'h02));
            check("timeout_mask_final", 64'(timeout_mask), 64'(8'h01));
            sb.delete();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
